// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extractor with a two-entry (output + skid) valid/ready pipeline.
// Decode is combinational on instr; only the decoded result is stored.
module imm_gen_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] imm_out,
  output logic [2:0]       imm_type,
  output logic             illegal
);

  localparam logic [2:0] T_I     = 3'd0;
  localparam logic [2:0] T_S     = 3'd1;
  localparam logic [2:0] T_B     = 3'd2;
  localparam logic [2:0] T_U     = 3'd3;
  localparam logic [2:0] T_J     = 3'd4;
  localparam logic [2:0] T_SHAMT = 3'd5;
  localparam logic [2:0] T_CSR   = 3'd6;
  localparam logic [2:0] T_NONE  = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_z;
  logic [63:0] dec_full;
  logic [WIDTH-1:0] dec_imm;
  logic [2:0]  dec_type;
  logic        dec_ill;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // All candidates are built at 64 bits and truncated, so sign extension always tracks instr[31].
  assign imm_i  = {{52{instr[31]}}, instr[31:20]};
  assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = (WIDTH == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
  assign imm_z  = {59'b0, instr[19:15]};

  always_comb begin
    dec_full = 64'b0;
    dec_type = T_NONE;
    dec_ill  = 1'b1;
    case (opcode)
      OP_IMM: begin
        dec_ill = 1'b0;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_full = imm_sh;
          dec_type = T_SHAMT;
        end else begin
          dec_full = imm_i;
          dec_type = T_I;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_full = imm_i;
        dec_type = T_I;
        dec_ill  = 1'b0;
      end
      OP_STORE: begin
        dec_full = imm_s;
        dec_type = T_S;
        dec_ill  = 1'b0;
      end
      OP_BRANCH: begin
        dec_full = imm_b;
        dec_type = T_B;
        dec_ill  = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec_full = imm_u;
        dec_type = T_U;
        dec_ill  = 1'b0;
      end
      OP_JAL: begin
        dec_full = imm_j;
        dec_type = T_J;
        dec_ill  = 1'b0;
      end
      OP_SYSTEM: begin
        if (funct3 != 3'b000) begin
          dec_full = imm_z;
          dec_type = T_CSR;
          dec_ill  = 1'b0;
        end
      end
      default: begin
        dec_full = 64'b0;
        dec_type = T_NONE;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign dec_imm = dec_full[WIDTH-1:0];

  logic             out_v_q, skid_v_q, in_rdy_q;
  logic [WIDTH-1:0] out_imm_q, skid_imm_q;
  logic [2:0]       out_type_q, skid_type_q;
  logic             out_ill_q, skid_ill_q;
  logic             in_fire, out_free, skid_v_nxt;

  assign in_fire  = in_valid & in_rdy_q;
  assign out_free = ~out_v_q | out_ready;

  // The skid register only fills while the output is stalled; any free output slot drains it.
  always_comb begin
    skid_v_nxt = skid_v_q;
    if (out_free)
      skid_v_nxt = 1'b0;
    else if (in_fire)
      skid_v_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      out_imm_q   <= '0;
      out_type_q  <= T_NONE;
      out_ill_q   <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_imm_q  <= '0;
      skid_type_q <= T_NONE;
      skid_ill_q  <= 1'b0;
      in_rdy_q    <= 1'b0;
    end else begin
      skid_v_q <= skid_v_nxt;
      in_rdy_q <= ~skid_v_nxt;
      if (out_free) begin
        if (skid_v_q) begin
          out_v_q    <= 1'b1;
          out_imm_q  <= skid_imm_q;
          out_type_q <= skid_type_q;
          out_ill_q  <= skid_ill_q;
        end else if (in_fire) begin
          out_v_q    <= 1'b1;
          out_imm_q  <= dec_imm;
          out_type_q <= dec_type;
          out_ill_q  <= dec_ill;
        end else begin
          out_v_q <= 1'b0;
        end
      end else if (in_fire) begin
        skid_imm_q  <= dec_imm;
        skid_type_q <= dec_type;
        skid_ill_q  <= dec_ill;
      end
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_v_q;
  assign imm_out   = out_imm_q;
  assign imm_type  = out_type_q;
  assign illegal   = out_ill_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting the immediate output width; legal values are 32 and 64.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, instr is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit, block can accept an instruction this cycle.
REQ-006 SHALL have port instr, input, 32 bits, raw RV instruction word.
REQ-007 SHALL have port out_valid, output, 1 bit, imm_out, imm_type and illegal are valid.
REQ-008 SHALL have port out_ready, input, 1 bit, downstream accepts the output this cycle.
REQ-009 SHALL have port imm_out, output, WIDTH bits, decoded immediate.
REQ-010 SHALL have port imm_type, output, 3 bits, format code: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 CSR-zimm, 7 NONE.
REQ-011 SHALL have port illegal, output, 1 bit, opcode has no immediate format.

Function
REQ-012 Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-013 Storage: one output register plus one skid register, for two entries total.
REQ-014 Latency: an accepted instruction SHALL appear on the outputs the next cycle when the output register is empty or is transferring that cycle.
REQ-015 in_ready SHALL be registered and SHALL equal "skid register empty"; it never depends combinationally on out_ready.
REQ-016 If the output is stalled (out_valid && !out_ready) and an input transfers, the decoded result SHALL go to the skid register, and in_ready SHALL be 0 the next cycle.
REQ-017 When the output transfers while the skid register is full, the skid contents SHALL move to the output register and in_ready SHALL return to 1 the next cycle.
REQ-018 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-019 Results SHALL be delivered in acceptance order, with no drops and no duplicates.
REQ-020 Decode is combinational on instr; only the decoded result is registered.
REQ-021 I-type decode applies to opcodes 0000011, 0010011 and 1100111: sign-extend instr[31:20].
REQ-022 SHAMT decode applies to opcode 0010011 with funct3 001 or 101: zero-extend instr[24:20] when WIDTH=32, or instr[25:20] when WIDTH=64; funct7 bits are excluded; type 5.
REQ-023 S-type decode applies to opcode 0100011: sign-extend {instr[31:25], instr[11:7]}.
REQ-024 B-type decode applies to opcode 1100011: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-025 U-type decode applies to opcodes 0110111 and 0010111: {instr[31:12], 12'b0}, sign-extended from bit 31 to WIDTH.
REQ-026 J-type decode applies to opcode 1101111: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-027 CSR decode applies to opcode 1110011 with funct3 != 000: zero-extend instr[19:15]; type 6.
REQ-028 All other opcodes, including 1110011 with funct3=000, SHALL produce imm_out 0, type 7, illegal 1; the instruction is still accepted and delivered.
REQ-029 All sign extension SHALL replicate instr[31] up to bit WIDTH-1.

Reset
REQ-030 While rst=1: out_valid 0, imm_out 0, imm_type 7, illegal 0, skid register empty, in_ready 0.
REQ-031 The first cycle after rst deasserts SHALL have in_ready 1.
REQ-032 Reset mid-operation SHALL discard both entries; inputs presented during reset SHALL NOT be accepted.

Verification
REQ-033 Scenario: WIDTH=32, out_ready=1, instr 0xFFF00093 (ADDI -1) -> next cycle out_valid 1, imm_out 0xFFFFFFFF, type 0.
REQ-034 Scenario: instr 0xFE000EE3 (BEQ -4) -> imm_out 0xFFFFFFFC, type 2; instr 0x4030D093 (SRAI 3) -> imm_out 3, type 5.
REQ-035 Scenario: WIDTH=64, instr 0x800000B7 (LUI) -> imm_out 0xFFFFFFFF80000000, type 3.
REQ-036 Scenario: out_ready=0 and three back-to-back in_valid words A, B, C -> A and B accepted, in_ready 0 while C is held; raising out_ready yields A, B, C in order, with outputs stable during the stall.
REQ-037 Scenario: instr 0x0000007F -> imm_out 0, type 7, illegal 1.
REQ-038 Scenario: rst pulsed with two entries buffered -> next cycle out_valid 0; the first cycle after release has in_ready 1; no stale data is emitted.
